// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage (P) and an
// external loader/debug port (E). Define DMEM_ARB_STATS_EN to add the statistics counters.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_req,
  input  logic                  pipe_we,
  input  logic [ADDR_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  pipe_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]           stat_stall_cnt,
  output logic [15:0]           stat_ext_grants,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic             owner_ext;
  logic             acc_we;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             grant_ext;
  logic             last_access;

  assign grant_ext   = ext_req & (~pipe_req | (starve_cnt == STV_MAX));
  assign last_access = (state == ACCESS) && (lat_cnt == '0);

  // NOTE: strobes are decoded from registered state rather than registered themselves,
  // so they drop the moment rst asserts and a write aborted before its last cycle never fires.
  assign mem_read   = (state == ACCESS) & ~acc_we;
  assign mem_write  = last_access & acc_we;
  assign ext_ack    = (state == DONE) & owner_ext;
  assign pipe_stall = pipe_req & ~((state == DONE) & ~owner_ext);

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_ext  <= 1'b0;
      acc_we     <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pipe_rdata <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pipe_req | ext_req) begin
            owner_ext <= grant_ext;
            acc_we    <= grant_ext ? ext_we    : pipe_we;
            mem_addr  <= grant_ext ? ext_addr  : pipe_addr;
            mem_wdata <= grant_ext ? ext_wdata : pipe_wdata;
            lat_cnt   <= LAT_INIT;
            state     <= ACCESS;
            if (grant_ext) begin
              starve_cnt <= '0;
            end else if (ext_req && (starve_cnt != STV_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!last_access) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            if (!acc_we) begin
              if (owner_ext) ext_rdata  <= mem_rdata;
              else           pipe_rdata <= mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt  <= '0;
      stat_ext_grants <= '0;
    end else begin
      if (pipe_stall) stat_stall_cnt <= stat_stall_cnt + 16'd1;
      if ((state == IDLE) && grant_ext) stat_ext_grants <= stat_ext_grants + 16'd1;
    end
  end
`endif

endmodule
